cpu_mem: RTL
============

# cpu_mem

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the EX stage. It takes the EX latch outputs and performs loads and stores against a variable-latency data memory through a req/ack handshake. Byte-lane steering and load extension happen here. The stage stalls upstream while an access is outstanding and registers the write-back payload for the WB stage.

## Interface
Parameters: none.

- clk  in  1  pipeline clock; all state updates on posedge
- clr_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX latch holds a real instruction
- in_pc  in  32  EX-latched PC
- in_ins  in  32  EX-latched instruction
- in_addr  in  32  EX ALU result: effective address, or write-back value for non-memory ops
- in_wdata  in  32  EX-latched second register operand (store data)
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- in_unsigned  in  1  zero-extend loads (lbu/lhu); 0 = sign-extend
- in_wb_en  in  1  instruction writes a register
- in_wb_reg  in  5  destination register
- stall  out  1  upstream must hold EX latch; inputs ignored while high
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, {in_addr[31:2], 2'b00}
- dmem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid same cycle
- dmem_rdata  in  32  load data
- out_valid, out_pc, out_ins, out_wb_en, out_wb_reg, out_wb_data  out  1/32/32/1/5/32  MEM latch to WB
- out_misaligned  out  1  latched instruction had an unaligned access (no memory op issued)

## Operation
- FSM states: IDLE, BUSY. Reset enters IDLE.
- IDLE, stall=0. Each posedge evaluates the inputs:
  - in_valid=0: out_valid<=0 (bubble). Other out_* are don't-care but held.
  - Non-memory op: out latch <= inputs, out_wb_data <= in_addr, out_misaligned<=0.
  - Memory op, misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No request is issued. out_valid<=1, out_misaligned<=1, out_wb_en<=0.
  - Memory op, aligned: capture op context, drive dmem_* outputs, set dmem_req<=1, go to BUSY, set out_valid<=0.
- If in_mem_read and in_mem_write are both set, the access is a read.
- BUSY, stall=1. dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stay stable.
  - On posedge with dmem_ack=1: dmem_req<=0, out latch <= captured context, out_valid<=1, state <= IDLE.
  - Loads: out_wb_data <= extended rdata.
  - Stores: out_wb_en<=0.
- dmem_ack in IDLE is ignored.
- Lanes are little-endian, lane = addr[1:0].
  - Byte: be = 1<<lane, wdata = {4{wdata[7:0]}}, load = rdata[8*lane+7:8*lane].
  - Half: be = 0011 (lane 0) or 1100 (lane 2), wdata = {2{wdata[15:0]}}, load = selected 16 bits.
  - Word: be = 1111.
  - Load extension uses in_unsigned: 0 = sign-extend, 1 = zero-extend.

## Timing
- Reset value of every output is 0. State is IDLE. Reset is effective immediately (async), including dmem_req.
- Reset during BUSY abandons the access. A late ack after reset is ignored.
- Non-memory or misaligned op: result visible after 1 posedge.
- Aligned access accepted at edge N: dmem_req=1 after N. Ack sampled high at edge N+k (k>=1) makes the result visible after N+k.
  - Minimum latency is 2 edges.
  - stall is high from after N through the ack edge, and low the cycle after.
- stall is combinational from state only. It has no combinational path from any input.
- No timeout: BUSY waits indefinitely for ack.

## Test plan
- Reset then clr_n=1: all outputs 0. Non-memory op in_addr=0x1234, wb_reg=8 -> next edge out_valid=1, out_wb_data=0x00001234, out_wb_reg=8, stall=0.
- sb with addr=0x1003, wdata=0xAB -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, we=1. ack after 3 cycles -> stall high 3 cycles, out_wb_en=0, out_valid=1.
- lb/lbu at addr=0x2002, rdata=0x00F00000 -> out_wb_data 0xFFFFFFF0 (lb) / 0x000000F0 (lbu). lh at addr=0x2002, rdata=0x80010000 -> 0xFFFF8001.
- lw addr=0x3002 -> no dmem_req, out_misaligned=1, out_wb_en=0, latency 1. Same for lh at addr=0x3001.
- Ack in the first BUSY cycle (lw addr=0x40, rdata=0xDEADBEEF) -> out_wb_data=0xDEADBEEF 2 edges after acceptance. Back-to-back non-memory op is accepted the next cycle.
- Assert clr_n=0 mid-BUSY -> dmem_req and stall drop immediately. A subsequent ack produces no out_valid.

Source files
------------

// File: rtl/cpu_mem_if.sv
// Data-memory req/ack bus between the MEM stage and the data memory.
// The master issues one word-aligned access and holds it until ack.
interface cpu_mem_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/cpu_mem.sv
// MIPS memory-access stage: byte-lane steering, load extension and a
// registered MEM/WB latch, stalling upstream while an access is pending.
module cpu_mem (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_ins,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic        in_wb_en,
   input  logic [4:0]  in_wb_reg,
   output logic        stall,
   cpu_mem_if.master   dmem,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_ins,
   output logic        out_wb_en,
   output logic [4:0]  out_wb_reg,
   output logic [31:0] out_wb_data,
   output logic        out_misaligned
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e      state_q;
   logic        req_q, we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;

   logic [31:0] c_pc_q, c_ins_q;
   logic [4:0]  c_wb_reg_q;
   logic        c_wb_en_q, c_load_q, c_uns_q;
   logic [1:0]  c_size_q, c_lane_q;

   logic        ov_q, oen_q, omis_q;
   logic [31:0] opc_q, oins_q, odata_q;
   logic [4:0]  oreg_q;

   logic        is_mem, misal;
   logic [1:0]  lane;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] rsh;
   logic [15:0] half;
   logic [31:0] ld_data;

   assign lane   = in_addr[1:0];
   assign is_mem = in_mem_read | in_mem_write;
   assign misal  = ((in_size == 2'b01) & in_addr[0])
                 | (in_size[1] & (|in_addr[1:0]));

   always_comb begin
      be_d    = 4'b0001 << lane;
      wdata_d = {4{in_wdata[7:0]}};
      unique case (1'b1)
         in_size[1]: begin
            be_d    = 4'b1111;
            wdata_d = in_wdata;
         end
         in_size[0]: begin
            be_d    = lane[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the lane captured at issue, not the live EX inputs.
   assign rsh  = dmem.rdata >> {c_lane_q, 3'b000};
   assign half = c_lane_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

   always_comb begin
      ld_data = {{24{~c_uns_q & rsh[7]}}, rsh[7:0]};
      unique case (1'b1)
         c_size_q[1]: ld_data = dmem.rdata;
         c_size_q[0]: ld_data = {{16{~c_uns_q & half[15]}}, half};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         c_pc_q     <= '0;
         c_ins_q    <= '0;
         c_wb_reg_q <= '0;
         c_wb_en_q  <= 1'b0;
         c_load_q   <= 1'b0;
         c_uns_q    <= 1'b0;
         c_size_q   <= '0;
         c_lane_q   <= '0;
         ov_q       <= 1'b0;
         oen_q      <= 1'b0;
         omis_q     <= 1'b0;
         opc_q      <= '0;
         oins_q     <= '0;
         odata_q    <= '0;
         oreg_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!in_valid) begin
                  ov_q <= 1'b0;
               end else if (!is_mem || misal) begin
                  ov_q    <= 1'b1;
                  opc_q   <= in_pc;
                  oins_q  <= in_ins;
                  oreg_q  <= in_wb_reg;
                  odata_q <= in_addr;
                  oen_q   <= is_mem ? 1'b0 : in_wb_en;
                  omis_q  <= is_mem;
               end else begin
                  c_pc_q     <= in_pc;
                  c_ins_q    <= in_ins;
                  c_wb_reg_q <= in_wb_reg;
                  c_wb_en_q  <= in_wb_en;
                  c_load_q   <= in_mem_read;
                  c_uns_q    <= in_unsigned;
                  c_size_q   <= in_size;
                  c_lane_q   <= lane;
                  req_q      <= 1'b1;
                  we_q       <= ~in_mem_read;
                  addr_q     <= {in_addr[31:2], 2'b00};
                  be_q       <= be_d;
                  wdata_q    <= wdata_d;
                  ov_q       <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (dmem.ack) begin
                  req_q   <= 1'b0;
                  ov_q    <= 1'b1;
                  opc_q   <= c_pc_q;
                  oins_q  <= c_ins_q;
                  oreg_q  <= c_wb_reg_q;
                  oen_q   <= c_wb_en_q & c_load_q;
                  omis_q  <= 1'b0;
                  if (c_load_q) odata_q <= ld_data;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall          = (state_q == BUSY);
   assign dmem.req       = req_q;
   assign dmem.we        = we_q;
   assign dmem.addr      = addr_q;
   assign dmem.be        = be_q;
   assign dmem.wdata     = wdata_q;
   assign out_valid      = ov_q;
   assign out_pc         = opc_q;
   assign out_ins        = oins_q;
   assign out_wb_en      = oen_q;
   assign out_wb_reg     = oreg_q;
   assign out_wb_data    = odata_q;
   assign out_misaligned = omis_q;

endmodule
